led_cube_fb_arbiter: RTL and testbench

LED_CUBE_FB_ARBITER -- requirements
Module: led_cube_fb_arbiter

---
 rtl/led_cube_fb_arbiter_if.sv | 39 +++
 rtl/led_cube_fb_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_led_cube_fb_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_cube_fb_arbiter_if.sv
// Frame-buffer port bundle for the LED cube arbiter: the refresh reader, two
// writers, the swap handshake and the single-port RAM bus.
interface led_cube_fb_arbiter_if;
  logic       ref_req;
  logic [5:0] ref_addr;
  logic       ref_gnt;
  logic [7:0] ref_rdata;
  logic       ref_rvalid;
  logic       str_req;
  logic [5:0] str_addr;
  logic [7:0] str_wdata;
  logic       str_lock;
  logic       str_gnt;
  logic       pat_req;
  logic [5:0] pat_addr;
  logic [7:0] pat_wdata;
  logic       pat_gnt;
  logic       frame_swap;
  logic       swap_done;
  logic       pat_starved;
  logic [6:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    output ref_req, ref_addr, str_req, str_addr, str_wdata, str_lock,
           pat_req, pat_addr, pat_wdata, frame_swap, mem_rdata,
    input  ref_gnt, ref_rdata, ref_rvalid, str_gnt, pat_gnt, swap_done,
           pat_starved, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  ref_req, ref_addr, str_req, str_addr, str_wdata, str_lock,
           pat_req, pat_addr, pat_wdata, frame_swap, mem_rdata,
    output ref_gnt, ref_rdata, ref_rvalid, str_gnt, pat_gnt, swap_done,
           pat_starved, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/led_cube_fb_arbiter.sv
// Single-port frame RAM arbiter: refresh reads beat round-robin writers.
// Define LED_CUBE_DOUBLE_BUFFER_EN for front/back bank swapping.
module led_cube_fb_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  led_cube_fb_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_STR_LOCKED = 2'd1;
  localparam logic [1:0] ST_SWAP_PEND  = 2'd2;
  localparam logic [4:0] STARVE_MAX    = 5'd16;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       swap_lat_r;
  logic       swap_lat_nxt_s;
  logic       swap_exec_s;
  logic       last_pat_r;
  logic [4:0] starve_cnt_r;
  logic [4:0] starve_nxt_s;
  logic       ref_gnt_s;
  logic       str_gnt_s;
  logic       pat_gnt_s;
  logic       bank_rd_s;
  logic       bank_wr_s;
  logic       rd_pipe_r;
  logic       ref_rvalid_r;
  logic       swap_done_r;
  logic       pat_starved_r;
  logic [6:0] mem_addr_r;
  logic       mem_we_r;
  logic [7:0] mem_wdata_r;

  // Same-cycle grant: refresh first, then writers (lock or round-robin)
  always_comb begin
    ref_gnt_s = 1'b0;
    str_gnt_s = 1'b0;
    pat_gnt_s = 1'b0;
    if (rst) begin
      ref_gnt_s = 1'b0;
    end else if (bus.ref_req) begin
      ref_gnt_s = 1'b1;
    end else if (state_r == ST_STR_LOCKED) begin
      str_gnt_s = bus.str_req;
    end else if (bus.str_req && bus.pat_req) begin
      str_gnt_s = last_pat_r;
      pat_gnt_s = ~last_pat_r;
    end else begin
      str_gnt_s = bus.str_req;
      pat_gnt_s = bus.pat_req;
    end
  end

  // Lock / swap sequencing; a swap seen while locked waits in swap_lat_r
  always_comb begin
    state_nxt_s    = state_r;
    swap_lat_nxt_s = swap_lat_r;
    swap_exec_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.str_lock) begin
          state_nxt_s    = ST_STR_LOCKED;
          swap_lat_nxt_s = swap_lat_r | bus.frame_swap;
        end else if (bus.frame_swap || swap_lat_r) begin
`ifdef LED_CUBE_DOUBLE_BUFFER_EN
          state_nxt_s    = ST_SWAP_PEND;
`else
          swap_exec_s    = 1'b1;
`endif
          swap_lat_nxt_s = 1'b0;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_STR_LOCKED: begin
        if (!bus.str_lock) begin
          state_nxt_s    = ST_IDLE;
`ifdef LED_CUBE_DOUBLE_BUFFER_EN
          swap_lat_nxt_s = swap_lat_r | bus.frame_swap;
`else
          swap_exec_s    = swap_lat_r | bus.frame_swap;
          swap_lat_nxt_s = 1'b0;
`endif
        end else begin
          state_nxt_s    = ST_STR_LOCKED;
          swap_lat_nxt_s = swap_lat_r | bus.frame_swap;
        end
      end
      ST_SWAP_PEND: begin
        if (!bus.ref_req && !str_gnt_s && !pat_gnt_s) begin
          swap_exec_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SWAP_PEND;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        swap_lat_nxt_s = 1'b0;
      end
    endcase
  end

  // Starve count saturates so pat_starved stays up while the denial lasts
  always_comb begin
    if (bus.pat_req && !pat_gnt_s) begin
      if (starve_cnt_r == STARVE_MAX) begin
        starve_nxt_s = STARVE_MAX;
      end else begin
        starve_nxt_s = starve_cnt_r + 5'd1;
      end
    end else begin
      starve_nxt_s = 5'd0;
    end
  end

`ifdef LED_CUBE_DOUBLE_BUFFER_EN
  logic front_bank_r;

  // Front bank flips in the cycle the pending swap executes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_bank_r <= 1'b0;
    end else if (swap_exec_s) begin
      front_bank_r <= ~front_bank_r;
    end
  end

  assign bank_rd_s = front_bank_r;
  assign bank_wr_s = ~front_bank_r;
`else
  assign bank_rd_s = 1'b0;
  assign bank_wr_s = 1'b0;
`endif

  // Control state, round-robin history and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      swap_lat_r    <= 1'b0;
      last_pat_r    <= 1'b1;
      starve_cnt_r  <= 5'd0;
      pat_starved_r <= 1'b0;
      swap_done_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      swap_lat_r    <= swap_lat_nxt_s;
      starve_cnt_r  <= starve_nxt_s;
      pat_starved_r <= (starve_nxt_s == STARVE_MAX);
      swap_done_r   <= swap_exec_s;
      if (str_gnt_s || pat_gnt_s) begin
        last_pat_r <= pat_gnt_s;
      end
    end
  end

  // RAM bus register and read-valid pipeline (RAM read adds one more cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_r   <= 7'd0;
      mem_we_r     <= 1'b0;
      mem_wdata_r  <= 8'd0;
      rd_pipe_r    <= 1'b0;
      ref_rvalid_r <= 1'b0;
    end else begin
      rd_pipe_r    <= ref_gnt_s;
      ref_rvalid_r <= rd_pipe_r;
      if (ref_gnt_s) begin
        mem_addr_r  <= {bank_rd_s, bus.ref_addr};
        mem_we_r    <= 1'b0;
      end else if (str_gnt_s) begin
        mem_addr_r  <= {bank_wr_s, bus.str_addr};
        mem_we_r    <= 1'b1;
        mem_wdata_r <= bus.str_wdata;
      end else if (pat_gnt_s) begin
        mem_addr_r  <= {bank_wr_s, bus.pat_addr};
        mem_we_r    <= 1'b1;
        mem_wdata_r <= bus.pat_wdata;
      end else begin
        mem_we_r    <= 1'b0;
      end
    end
  end

  assign bus.ref_gnt     = ref_gnt_s;
  assign bus.str_gnt     = str_gnt_s;
  assign bus.pat_gnt     = pat_gnt_s;
  assign bus.ref_rvalid  = ref_rvalid_r;
  assign bus.ref_rdata   = ref_rvalid_r ? bus.mem_rdata : 8'd0;
  assign bus.swap_done   = swap_done_r;
  assign bus.pat_starved = pat_starved_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_led_cube_fb_arbiter.sv
// Self-checking bench for led_cube_fb_arbiter: grant table, corner sequences
// and a random run against a cycle-level reference model.
module tb_led_cube_fb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  led_cube_fb_arbiter_if bus();

  led_cube_fb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit ref_req; logic [5:0] ref_addr;
    bit str_req; logic [5:0] str_addr; logic [7:0] str_wdata; bit str_lock;
    bit pat_req; logic [5:0] pat_addr; logic [7:0] pat_wdata; bit frame_swap;
  } in_t;

  typedef struct { bit ref_req; bit str_req; bit pat_req; logic [2:0] exp_gnt; } tv_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame RAM: one-cycle registered read, preloaded on the first edge
  logic [7:0] ram [0:127];
  bit         ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 128; i++) ram[i] <= 8'(i * 3 + 1);
      ram_ready <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference model state
  logic [7:0] shadow [0:127];
  bit m_locked, m_pend, m_owed, m_last_pat, m_front;
  int m_starve;
  logic [6:0] e_addr; bit e_we; logic [7:0] e_wdata;
  bit e_rv1, e_rvalid; logic [7:0] e_rd1, e_rdata;
  bit e_done, e_starved;
  bit pw_valid; logic [6:0] pw_addr; logic [7:0] pw_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_pend = 0; m_owed = 0; m_last_pat = 1; m_front = 0; m_starve = 0;
    e_addr = 7'd0; e_we = 0; e_wdata = 8'd0;
    e_rv1 = 0; e_rvalid = 0; e_rd1 = 8'd0; e_rdata = 8'd0;
    e_done = 0; e_starved = 0; pw_valid = 0;
  endtask

  task automatic model_update(input in_t v, input bit gr, input bit gs, input bit gp);
    bit b_rd, b_wr;
`ifdef LED_CUBE_DOUBLE_BUFFER_EN
    b_rd = m_front; b_wr = ~m_front;
`else
    b_rd = 1'b0; b_wr = 1'b0;
`endif
    if (pw_valid) shadow[pw_addr] = pw_data;
    pw_valid = 0;
    e_rvalid = e_rv1; e_rdata = e_rd1; e_rv1 = gr;
    if (gr) begin
      e_addr = {b_rd, v.ref_addr}; e_we = 0; e_rd1 = shadow[e_addr];
    end else if (gs || gp) begin
      e_addr = gs ? {b_wr, v.str_addr} : {b_wr, v.pat_addr};
      e_wdata = gs ? v.str_wdata : v.pat_wdata;
      e_we = 1; pw_valid = 1; pw_addr = e_addr; pw_data = e_wdata; m_last_pat = gp;
    end else begin
      e_we = 0;
    end
    if (v.pat_req && !gp) m_starve = (m_starve < 16) ? m_starve + 1 : 16;
    else m_starve = 0;
    e_starved = (m_starve == 16);
    e_done = 0;
    if (m_pend) begin
      if (!v.ref_req && !gs && !gp) begin m_front = ~m_front; e_done = 1; m_pend = 0; end
    end else if (m_locked) begin
      m_owed = m_owed | v.frame_swap;
      if (!v.str_lock) begin
        m_locked = 0;
`ifndef LED_CUBE_DOUBLE_BUFFER_EN
        if (m_owed) begin e_done = 1; m_owed = 0; end
`endif
      end
    end else if (v.str_lock) begin
      m_locked = 1; m_owed = m_owed | v.frame_swap;
    end else if (v.frame_swap || m_owed) begin
      m_owed = 0;
`ifdef LED_CUBE_DOUBLE_BUFFER_EN
      m_pend = 1;
`else
      e_done = 1;
`endif
    end
  endtask

  // One clock cycle: drive after the edge, check on the falling edge, advance model
  task automatic step(input in_t v);
    bit gr, gs, gp;
    @(posedge clk); #1;
    rst = v.rst;
    bus.ref_req = v.ref_req; bus.ref_addr = v.ref_addr;
    bus.str_req = v.str_req; bus.str_addr = v.str_addr; bus.str_wdata = v.str_wdata;
    bus.str_lock = v.str_lock;
    bus.pat_req = v.pat_req; bus.pat_addr = v.pat_addr; bus.pat_wdata = v.pat_wdata;
    bus.frame_swap = v.frame_swap;
    if (v.rst) model_reset();
    @(negedge clk);
    gr = !v.rst && v.ref_req;
    gs = !v.rst && !v.ref_req && v.str_req && (m_locked || !v.pat_req || m_last_pat);
    gp = !v.rst && !v.ref_req && v.pat_req && !m_locked && (!v.str_req || !m_last_pat);
    chk("ref_gnt", 32'(bus.ref_gnt), 32'(gr));
    chk("str_gnt", 32'(bus.str_gnt), 32'(gs));
    chk("pat_gnt", 32'(bus.pat_gnt), 32'(gp));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (e_we || v.rst) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    chk("ref_rvalid", 32'(bus.ref_rvalid), 32'(e_rvalid));
    chk("ref_rdata", 32'(bus.ref_rdata), e_rvalid ? 32'(e_rdata) : 32'd0);
    chk("swap_done", 32'(bus.swap_done), 32'(e_done));
    chk("pat_starved", 32'(bus.pat_starved), 32'(e_starved));
    if (!v.rst) model_update(v, gr, gs, gp);
  endtask

  function automatic in_t mk(input bit r, input bit rq, input logic [5:0] ra,
                             input bit sq, input logic [5:0] sa, input bit lk,
                             input bit pq, input logic [5:0] pa, input bit fs);
    in_t v;
    v.rst = r; v.ref_req = rq; v.ref_addr = ra;
    v.str_req = sq; v.str_addr = sa; v.str_wdata = 8'($urandom); v.str_lock = lk;
    v.pat_req = pq; v.pat_addr = pa; v.pat_wdata = 8'($urandom); v.frame_swap = fs;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv_t tbl [12];
    in_t v;
    int  swaps, lock_left, seen;
    logic [6:0] a_exp;

    tbl[0]  = '{0, 1, 1, 3'b010};  tbl[1]  = '{0, 1, 1, 3'b001};
    tbl[2]  = '{0, 1, 1, 3'b010};  tbl[3]  = '{0, 1, 1, 3'b001};
    tbl[4]  = '{1, 1, 1, 3'b100};  tbl[5]  = '{0, 1, 0, 3'b010};
    tbl[6]  = '{0, 1, 1, 3'b001};  tbl[7]  = '{0, 0, 1, 3'b001};
    tbl[8]  = '{0, 1, 1, 3'b010};  tbl[9]  = '{0, 0, 0, 3'b000};
    tbl[10] = '{1, 0, 0, 3'b100};  tbl[11] = '{1, 0, 1, 3'b100};

    for (int i = 0; i < 128; i++) shadow[i] = 8'(i * 3 + 1);
    model_reset();
    bus.ref_req = 0; bus.ref_addr = 0; bus.str_req = 0; bus.str_addr = 0;
    bus.str_wdata = 0; bus.str_lock = 0; bus.pat_req = 0; bus.pat_addr = 0;
    bus.pat_wdata = 0; bus.frame_swap = 0;

    // Reset state, then the grant table (first four rows: STR,PAT,STR,PAT)
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      step(mk(0, tbl[i].ref_req, 6'(i * 5), tbl[i].str_req, 6'(i + 20), 0,
              tbl[i].pat_req, 6'(i + 40), 0));
      chk("tbl_gnt", 32'({bus.ref_gnt, bus.str_gnt, bus.pat_gnt}), 32'(tbl[i].exp_gnt));
    end
    step(mk(0, 0, 0, 0, 0, 0, 1, 6'd50, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // 64-cycle locked burst with the pattern writer starving; swap requested mid-lock
    swaps = 0;
    for (int k = 0; k < 64; k++) begin
      step(mk(0, 0, 0, 1, 6'(k), 1, 1, 6'd9, k == 20));
      chk("lock_pat_gnt", 32'(bus.pat_gnt), 32'd0);
      chk("lock_starved", 32'(bus.pat_starved), 32'(k >= 16));
      swaps += int'(bus.swap_done);
    end
    chk("no_swap_in_lock", 32'(swaps), 32'd0);
    seen = 0;
    for (int k = 0; k < 4 && seen == 0; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 1, 6'd9, 0));
      swaps += int'(bus.swap_done);
      if (bus.pat_gnt) seen = 1;
    end
    chk("pat_after_lock", 32'(seen), 32'd1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    swaps += int'(bus.swap_done);
    chk("starve_cleared", 32'(bus.pat_starved), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      swaps += int'(bus.swap_done);
    end
    chk("swap_once", 32'(swaps), 32'd1);

    // Refresh of byte 0 lands in the new front bank
    step(mk(0, 1, 6'd0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef LED_CUBE_DOUBLE_BUFFER_EN
    chk("swap_bank_addr", 32'(bus.mem_addr), 32'h40);
`else
    chk("swap_bank_addr", 32'(bus.mem_addr), 32'h00);
`endif

    // Refresh beats the stream writer; address, then data two cycles on
    step(mk(0, 1, 6'd5, 1, 6'd33, 0, 0, 0, 0));
    chk("ref_vs_str", 32'({bus.ref_gnt, bus.str_gnt}), 32'b10);
`ifdef LED_CUBE_DOUBLE_BUFFER_EN
    a_exp = 7'h45;
`else
    a_exp = 7'h05;
`endif
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("ref_addr_out", 32'(bus.mem_addr), 32'(a_exp));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("ref_rvalid_n2", 32'(bus.ref_rvalid), 32'd1);
    chk("ref_rdata_n2", 32'(bus.ref_rdata), 32'(shadow[a_exp]));

    // Reset the cycle after a refresh grant kills the in-flight read
    step(mk(0, 1, 6'd7, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 1, 6'd3, 0, 0, 0, 0));
    chk("rst_rvalid", 32'(bus.ref_rvalid), 32'd0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("post_rst_rvalid", 32'(bus.ref_rvalid), 32'd0);
    end
    step(mk(0, 0, 0, 1, 6'd12, 0, 0, 0, 0));
    chk("post_rst_str", 32'(bus.str_gnt), 32'd1);

    // Random traffic with occasional bursts, swaps and resets
    lock_left = 0;
    for (int n = 0; n < 700; n++) begin
      if (lock_left > 0) lock_left--;
      else if ($urandom_range(39) == 0) lock_left = 64;
      v = mk($urandom_range(249) == 0, $urandom_range(9) < 4, 6'($urandom),
             $urandom_range(1) == 1, 6'($urandom), lock_left > 0,
             $urandom_range(1) == 1, 6'($urandom), $urandom_range(19) == 0);
      step(v);
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
